// File: rtl/vga_timing_recover.sv
// vga_timing_recover: recovers H/V position from HSYNC/VSYNC, measures line and frame length,
// and qualifies the stream against nominal timing. Optional ERR_CNT output: VGA_RECOV_ERR_CNT_EN.
module vga_timing_recover #(
    parameter int   H_TOTAL     = 800,
    parameter int   V_TOTAL     = 525,
    parameter int   H_START     = 144,
    parameter int   V_START     = 35,
    parameter int   H_ACTIVE    = 640,
    parameter int   V_ACTIVE    = 480,
    parameter int   LOCK_FRAMES = 2,
    parameter logic SYNC_ACT    = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HS_IN,
    input  logic        VS_IN,
    output logic [10:0] H_Q,
    output logic [9:0]  V_Q,
    output logic [10:0] LINE_LEN,
    output logic [9:0]  LINE_CNT,
    output logic        FRAME_START,
    output logic        DE,
    output logic        LOCKED,
    output logic        ERR_PULSE
`ifdef VGA_RECOV_ERR_CNT_EN
    ,
    output logic [7:0]  ERR_CNT
`endif
);

    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_t;

    state_t      state;
    logic        hs_r1, hs_r2, vs_r1, vs_r2, vs_pend;
    logic [3:0]  good_cnt;
    logic        hs_edge, vs_edge, fs, lost, err, lock_set, locked_n, de_n;
    logic [10:0] h_sat, h_n;
    logic [9:0]  v_sat, v_n;

    // edge detection, saturating next-state counters and error/lock qualification
    always_comb begin
        hs_edge  = (hs_r1 == SYNC_ACT) && (hs_r2 != SYNC_ACT);
        vs_edge  = (vs_r1 == SYNC_ACT) && (vs_r2 != SYNC_ACT);
        fs       = hs_edge && (vs_pend || vs_edge);
        h_sat    = (H_Q == 11'h7FF) ? H_Q : H_Q + 11'd1;
        v_sat    = (V_Q == 10'h3FF) ? V_Q : V_Q + 10'd1;
        h_n      = hs_edge ? 11'd0 : h_sat;
        v_n      = fs ? 10'd0 : hs_edge ? v_sat : V_Q;
        lost     = H_Q == 11'h7FF;
        err      = (state != S_SEARCH) &&
                   (lost || (hs_edge && int'(h_sat) != H_TOTAL) || (fs && int'(v_sat) != V_TOTAL));
        lock_set = (state == S_TRACK) && fs && !err && (int'(good_cnt) + 1 >= LOCK_FRAMES);
        locked_n = !err && (LOCKED || lock_set);
        de_n     = locked_n &&
                   int'(h_n) >= H_START && int'(h_n) < H_START + H_ACTIVE &&
                   int'(v_n) >= V_START && int'(v_n) < V_START + V_ACTIVE;
    end

    // two-stage sync sampling; resets to the inactive level so no false edge follows reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_r1 <= !SYNC_ACT;
            hs_r2 <= !SYNC_ACT;
            vs_r1 <= !SYNC_ACT;
            vs_r2 <= !SYNC_ACT;
        end else begin
            hs_r1 <= HS_IN;
            hs_r2 <= hs_r1;
            vs_r1 <= VS_IN;
            vs_r2 <= vs_r1;
        end
    end

    // position counters, line/frame measurement and pending-vsync tracking
    always_ff @(posedge CLK) begin
        if (RST) begin
            H_Q         <= '0;
            V_Q         <= '0;
            LINE_LEN    <= '0;
            LINE_CNT    <= '0;
            FRAME_START <= 1'b0;
            vs_pend     <= 1'b0;
        end else begin
            H_Q         <= h_n;
            V_Q         <= v_n;
            FRAME_START <= fs;
            vs_pend     <= fs ? 1'b0 : (vs_pend || vs_edge);
            if (hs_edge) LINE_LEN <= h_sat;
            if (fs) LINE_CNT <= v_sat;
        end
    end

    // lock FSM with registered LOCKED, ERR_PULSE and DE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_SEARCH;
            good_cnt  <= '0;
            LOCKED    <= 1'b0;
            ERR_PULSE <= 1'b0;
            DE        <= 1'b0;
        end else begin
            ERR_PULSE <= err;
            LOCKED    <= locked_n;
            DE        <= de_n;
            if (err) begin
                state    <= S_SEARCH;
                good_cnt <= '0;
            end else if (fs && state == S_SEARCH) begin
                state    <= S_TRACK;
                good_cnt <= '0;
            end else if (fs && state == S_TRACK) begin
                good_cnt <= good_cnt + 4'd1;
                if (lock_set) state <= S_LOCKED;
            end
        end
    end

`ifdef VGA_RECOV_ERR_CNT_EN
    // saturating count of timing violations, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) ERR_CNT <= '0;
        else if (ERR_PULSE && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_recover.sv
// tb_vga_timing_recover: randomized sync stream, line-level reference model and scoreboard
module tb_vga_timing_recover;

    localparam int HT = 40, VT = 10, HS0 = 6, HA = 28, VS0 = 2, VA = 6, LF = 2;

    logic        clk = 1'b0, rst = 1'b1, hs_in = 1'b1, vs_in = 1'b1;
    logic [10:0] h_q, line_len;
    logic [9:0]  v_q, line_cnt;
    logic        frame_start, de, locked, err_pulse;
`ifdef VGA_RECOV_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    vga_timing_recover #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS0), .V_START(VS0),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF), .SYNC_ACT(1'b0)
    ) dut (
        .CLK(clk), .RST(rst), .HS_IN(hs_in), .VS_IN(vs_in),
        .H_Q(h_q), .V_Q(v_q), .LINE_LEN(line_len), .LINE_CNT(line_cnt),
        .FRAME_START(frame_start), .DE(de), .LOCKED(locked),
`ifdef VGA_RECOV_ERR_CNT_EN
        .ERR_CNT(err_cnt),
`endif
        .ERR_PULSE(err_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int start; int hq_end;
        bit chk_len; int len;
        int v;
        bit chk_lc; int lc;
        bit fs; bit locked; int err_n; int de_n;
    } item_t;

    item_t q[$];
    int errors = 0, checks = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model state, expressed per line / per frame
    int m_prev_len = 0, m_v = 0, m_lc = 0, m_good = 0, style = 0;
    bit m_plen_ok = 0, m_lc_ok = 1, m_pend = 0, m_track = 0, m_locked = 0;

    function automatic int clampi(int x, int lo, int hi);
        return x < lo ? lo : x > hi ? hi : x;
    endfunction

    task automatic model_reset();
        m_plen_ok = 0; m_v = 0; m_lc = 0; m_lc_ok = 1;
        m_pend = 0; m_track = 0; m_locked = 0; m_good = 0;
    endtask

    // mode: 0 none, 1 vsync coincident with hsync, 2 vsync mid-line, 3 two vsyncs mid-line
    task automatic send_line(int len, int mode, int rst_off);
        item_t it;
        bit fs, err;
        fs = m_pend || mode == 1;
        it.start   = cyc + 2;
        it.hq_end  = len - 1 > 2047 ? 2047 : len - 1;
        it.chk_len = m_plen_ok;
        it.len     = m_prev_len > 2047 ? 2047 : m_prev_len;
        if (fs) begin
            it.chk_lc = 1;
            m_lc = m_v + 1;
            m_v = 0;
        end else begin
            it.chk_lc = m_lc_ok;
            if (m_v < 1023) m_v++;
        end
        it.lc = m_lc;
        it.v  = m_v;
        err = m_track && ((m_plen_ok && m_prev_len != HT) || (fs && m_lc != VT));
        if (err) begin
            m_track = 0; m_locked = 0;
        end else if (fs && !m_track) begin
            m_track = 1; m_good = 0;
        end else if (fs && !m_locked) begin
            m_good++;
            if (m_good >= LF) m_locked = 1;
        end
        it.fs     = fs;
        it.locked = m_locked;
        it.err_n  = err;
        it.de_n   = (m_locked && m_v >= VS0 && m_v < VS0 + VA) ?
                    clampi((len > 2048 ? 2048 : len) - HS0, 0, HA) : 0;
        if (len > 2048 && m_track) begin
            it.err_n++; m_track = 0; m_locked = 0;
        end
        q.push_back(it);
        m_pend = mode >= 2;
        m_prev_len = len;
        m_plen_ok = 1;
        for (int o = 0; o < len; o++) begin
            hs_in = o < 4 ? 1'b0 : 1'b1;
            vs_in = (mode == 1 && o < 3) ||
                    (mode >= 2 && o >= len / 2 && o < len / 2 + 3) ||
                    (mode == 3 && o >= len / 4 && o < len / 4 + 3) ? 1'b0 : 1'b1;
            if (o == rst_off) rst = 1'b1;
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
                check("rst_h_q", h_q, 0);
                check("rst_v_q", v_q, 0);
                check("rst_locked", locked, 0);
                check("rst_de", de, 0);
                model_reset();
            end
        end
    endtask

    task automatic send_frame(int n, int bad_i, int bad_len, int rst_i);
        int nxt, mode, len;
        for (int i = 0; i < n; i++) begin
            len  = i == bad_i ? bad_len : HT;
            mode = (i == 0 && style == 0) ? 1 : 0;
            if (i == n - 1) begin
                nxt = $urandom_range(0, 2);
                if (nxt != 0) mode = nxt + 1;
                style = nxt;
            end
            send_line(len, mode, i == rst_i ? 15 : -1);
        end
    endtask

    task automatic good_frames(int k);
        for (int i = 0; i < k; i++) send_frame(VT, -1, 0, -1);
    endtask

    // monitor: a line is presented when H_Q returns to zero; compares against queued expectations
    item_t cur;
    bit    cur_ok = 0;
    int    prev_hq = 0, n_err = 0, n_de = 0, n_fs = 0;

    always @(negedge clk) begin
        if (rst) begin
            cur_ok = 0;
            prev_hq = 0;
        end else begin
            if (h_q == 0 && prev_hq != 0) begin
                if (cur_ok) begin
                    check("h_q_line_end", prev_hq, cur.hq_end);
                    check("err_pulses", n_err, cur.err_n);
                    check("de_cycles", n_de, cur.de_n);
                    check("frame_starts", n_fs, cur.fs);
                end
                if (q.size() == 0) begin
                    checks++; errors++; cur_ok = 0;
                    $display("FAIL unexpected_line: got line start at cycle %0d expected none", cyc);
                end else begin
                    cur = q.pop_front();
                    cur_ok = 1;
                    check("line_start_cycle", cyc, cur.start);
                    if (cur.chk_len) check("line_len", line_len, cur.len);
                    check("v_q", v_q, cur.v);
                    if (cur.chk_lc) check("line_cnt", line_cnt, cur.lc);
                    check("locked", locked, cur.locked);
                end
                n_err = err_pulse; n_de = de; n_fs = frame_start;
            end else begin
                n_err += err_pulse; n_de += de; n_fs += frame_start;
            end
            prev_hq = h_q;
        end
    end

    initial begin
        int kind;
        repeat (3) @(posedge clk);
        #1;
        check("reset_h_q", h_q, 0);
        check("reset_v_q", v_q, 0);
        check("reset_line_len", line_len, 0);
        check("reset_line_cnt", line_cnt, 0);
        check("reset_frame_start", frame_start, 0);
        check("reset_de", de, 0);
        check("reset_locked", locked, 0);
        check("reset_err_pulse", err_pulse, 0);
        rst = 1'b0;
        model_reset();
        repeat (5) begin @(posedge clk); #1; end
        send_frame(4, -1, 0, -1);
        good_frames(4);
        check("locked_after_sync", locked, 1);
        check("line_len_nominal", line_len, HT);
        check("line_cnt_nominal", line_cnt, VT);
        send_frame(VT, $urandom_range(1, VT - 2), HT - 1, -1);
        check("unlocked_after_short_line", locked, 0);
        good_frames(5);
        check("relocked_after_short_line", locked, 1);
        for (int r = 0; r < 8; r++) begin
            kind = $urandom_range(0, 3);
            if (kind == 2) send_frame(VT, $urandom_range(0, VT - 1), $urandom_range(0, 1) ? HT + 1 : HT - 1, -1);
            else if (kind == 3) send_frame($urandom_range(0, 1) ? VT + 1 : VT - 1, -1, 0, -1);
            else send_frame(VT, -1, 0, -1);
        end
        good_frames(5);
        check("locked_before_lost", locked, 1);
        send_frame(VT, 3, 3000, -1);
        check("unlocked_after_lost", locked, 0);
`ifdef VGA_RECOV_ERR_CNT_EN
        check("err_cnt_nonzero", int'(err_cnt != 0), 1);
`endif
        good_frames(5);
        check("locked_before_reset", locked, 1);
        send_frame(VT, -1, 0, 4);
        good_frames(5);
        check("relocked_after_reset", locked, 1);
        send_line(HT, 0, -1);
        repeat (4) begin @(posedge clk); #1; end
        check("pending_lines", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
